// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, buffers in-order responses
// toward decode, and discards in-flight responses after a pcsrc redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        pcsrc,
    input  logic [31:0] pctarget,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] live_q, live_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [31:0]     buf_data_q [DEPTH];
    logic [31:0]     buf_data_d [DEPTH];
    logic [31:0]     buf_pc_q   [DEPTH];
    logic [31:0]     buf_pc_d   [DEPTH];
    logic            req_valid_q, req_valid_d;
    logic            instr_valid_q, instr_valid_d;

    logic            acc, pop, rsp_ok, rsp_live, push;
    logic [31:0]     rsp_pc;
    logic [CntW+1:0] budget;
    logic            unused_tgt_lsb;

    assign unused_tgt_lsb = ^pctarget[1:0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        acc      = req_valid_q & imem_req_ready;
        pop      = instr_valid_q & instr_ready;
        rsp_ok   = imem_rsp_valid & ((live_q != '0) | (drop_q != '0));
        // Dropped requests are always older than live ones, so they drain first.
        rsp_live = rsp_ok & (drop_q == '0);
        push     = rsp_live & ~pcsrc;
        // Live requests are consecutive words ending just below fetch_pc.
        rsp_pc   = fetch_pc_q - (32'(live_q) << 2);

        fetch_pc_d = fetch_pc_q;
        if (acc) fetch_pc_d = fetch_pc_q + 32'd4;
        if (pcsrc) fetch_pc_d = {pctarget[31:2], 2'b00};

        if (pcsrc) begin
            live_d = '0;
            drop_d = drop_q + live_q + CntW'(acc) - CntW'(rsp_ok);
        end else begin
            live_d = live_q + CntW'(acc) - CntW'(rsp_live);
            drop_d = drop_q - CntW'(rsp_ok & ~rsp_live);
        end

        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (pop) begin
            head_d  = ptr_inc(head_q);
            count_d = count_d - 1'b1;
        end
        if (push) begin
            buf_data_d[tail_q] = imem_rsp_data;
            buf_pc_d[tail_q]   = rsp_pc;
            tail_d             = ptr_inc(tail_q);
            count_d            = count_d + 1'b1;
        end
        if (pcsrc) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        case (state_q)
            StIdle:           state_d = StFetch;
            StFetch, StFlush: state_d = (drop_d != '0) ? StFlush : StFetch;
            default:          state_d = StIdle;
        endcase

        budget        = (CntW+2)'(live_d) + (CntW+2)'(drop_d) + (CntW+2)'(count_d);
        req_valid_d   = (state_d != StIdle) && (budget < (CntW+2)'(DEPTH));
        instr_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            live_q        <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= RESET_PC;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            live_q        <= live_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            buf_data_q    <= buf_data_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = buf_data_q[head_q];
    assign pc             = buf_pc_q[head_q];
    assign pcplus4        = pc + 32'd4;
    assign op             = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7         = instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based model of in-flight requests and the
// decode buffer predicts every output; directed phases cover bring-up, stall, redirect, wrap, reset.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        pcsrc;
    logic [31:0] pctarget;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, pc, pcplus4;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pcsrc          (pcsrc),
        .pctarget       (pctarget),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .pcplus4        (pcplus4),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7)
    );

    typedef struct packed { logic [31:0] addr; logic stale; } fl_t;
    typedef struct packed { logic [31:0] addr; int unsigned due; } mrsp_t;

    fl_t         fl_q[$];   // requests accepted, awaiting response
    logic [31:0] buf_q[$];  // addresses of words waiting for decode
    mrsp_t       mem_q[$];  // memory responses scheduled

    logic [31:0] m_fetch_pc;
    logic        m_idle, m_just_reset;
    int unsigned cyc, last_due;
    int          n_tests, n_fail, n_hs;

    int unsigned p_rdy, p_irdy, p_pcsrc, extra;
    logic        rst_drv, force_pcsrc, spurious;
    logic [31:0] force_target;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic exp_req_valid();
        return !m_idle && ((fl_q.size() + buf_q.size()) < DEPTH);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fetch_pc   = RESET_PC;
        m_idle       = 1'b1;
        m_just_reset = 1'b1;
        fl_q.delete();
        buf_q.delete();
        mem_q.delete();
        last_due = cyc;
    endtask

    // Called just after a falling edge; checks, drives, crosses one rising edge.
    task automatic step();
        logic [31:0] w, t, exp_pc;
        logic        erv, eiv, acc, pop, rsp;
        int unsigned due;
        fl_t         f;
        erv = exp_req_valid();
        eiv = (buf_q.size() != 0);
        check_eq("imem_req_valid", 32'(imem_req_valid), 32'(erv));
        if (erv) check_eq("imem_addr", imem_addr, m_fetch_pc);
        check_eq("instr_valid", 32'(instr_valid), 32'(eiv));
        if (eiv) begin
            exp_pc = buf_q[0];
            w      = mem_word(exp_pc);
            check_eq("pc", pc, exp_pc);
            check_eq("instr", instr, w);
            check_eq("pcplus4", pcplus4, exp_pc + 32'd4);
            check_eq("op", 32'(op), 32'(w[6:0]));
            check_eq("funct3", 32'(funct3), 32'(w[14:12]));
            check_eq("funct7", 32'(funct7), 32'(w[31:25]));
        end
        if (m_just_reset) begin
            check_eq("reset_instr", instr, 32'h0);
            check_eq("reset_pc", pc, RESET_PC);
            check_eq("reset_pcplus4", pcplus4, RESET_PC + 32'd4);
        end

        rsp = 1'b0;
        imem_rsp_data = $urandom;
        if (spurious) begin
            rsp      = 1'b1;
            spurious = 1'b0;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            rsp           = 1'b1;
            imem_rsp_data = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        imem_rsp_valid = rsp;
        imem_req_ready = ($urandom_range(0, 99) < p_rdy);
        instr_ready    = ($urandom_range(0, 99) < p_irdy);
        t = $urandom;
        pcsrc    = force_pcsrc || ($urandom_range(0, 99) < p_pcsrc);
        pctarget = force_pcsrc ? force_target :
                   ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | (t & 32'h1F)) : (t & 32'h3FF);
        force_pcsrc = 1'b0;
        rst = rst_drv;
        acc = rst_drv && erv && imem_req_ready;
        pop = rst_drv && eiv && instr_ready;
        if (imem_req_valid && imem_req_ready) n_hs++;

        @(posedge clk);
        if (!rst_drv) begin
            cyc++;
            model_reset();
        end else begin
            m_idle       = 1'b0;
            m_just_reset = 1'b0;
            if (pop) void'(buf_q.pop_front());
            if (pcsrc) foreach (fl_q[i]) fl_q[i].stale = 1'b1;
            if (rsp && fl_q.size() != 0) begin
                f = fl_q.pop_front();
                if (!f.stale) buf_q.push_back(f.addr);
            end
            if (acc) begin
                fl_q.push_back('{addr: m_fetch_pc, stale: pcsrc});
                due = cyc + 1 + $urandom_range(0, extra);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: m_fetch_pc, due: due});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (pcsrc) begin
                m_fetch_pc = pctarget & 32'hFFFF_FFFC;
                buf_q.delete();
            end
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        step();
        rst_drv = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until instr_valid shows the wanted pc, then checks it was seen.
    task automatic expect_delivery(input string tag, input logic [31:0] want_pc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (instr_valid && pc == want_pc) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int   first;
        logic found;
        n_tests = 0; n_fail = 0; n_hs = 0; cyc = 0; last_due = 0;
        rst = 1'b0; rst_drv = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        pcsrc = 1'b0; pctarget = '0; instr_ready = 1'b0;
        p_rdy = 100; p_irdy = 100; p_pcsrc = 0; extra = 0;
        force_pcsrc = 1'b0; force_target = '0; spurious = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();

        // Bring-up: ideal memory and decode.
        rst_drv = 1'b1;
        first = -1;
        for (int k = 0; k < 20; k++) begin
            if (instr_valid && first < 0) first = k;
            step();
        end
        check_eq("first_valid_cycle", 32'(first), 32'd3);

        // Decode stalled: only DEPTH requests may go out; head holds.
        do_reset();
        p_irdy = 0;
        n_hs = 0;
        run(10);
        check_eq("reqs_while_stalled", 32'(n_hs), 32'(DEPTH));
        check_eq("held_head_pc", pc, RESET_PC);
        p_irdy = 100;
        run(5);

        // Redirect with two requests still in flight.
        do_reset();
        extra = 2;
        run(3);
        force_pcsrc = 1'b1; force_target = 32'h0000_0103;
        step();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq("redirect_req_seen", 32'(found), 32'd1);
        if (found) check_eq("redirect_addr", imem_addr, 32'h0000_0100);
        expect_delivery("first_pc_after_redirect", 32'h0000_0100);

        // Redirect in a cycle that also has a response and an acceptance.
        do_reset();
        extra = 0;
        run(6);
        force_pcsrc = 1'b1; force_target = 32'h0000_0200;
        step();
        expect_delivery("pc_after_busy_redirect", 32'h0000_0200);
        run(4);

        // Address wrap at the top of memory.
        force_pcsrc = 1'b1; force_target = 32'hFFFF_FFF8;
        step();
        expect_delivery("wrap_top_seen", 32'hFFFF_FFFC);
        check_eq("pcplus4_wrap", pcplus4, 32'h0);
        expect_delivery("wrap_zero_seen", 32'h0000_0000);

        // Reset with requests outstanding, then a stray response while idle.
        do_reset();
        extra = 2; p_irdy = 0;
        run(3);
        do_reset();
        spurious = 1'b1;
        extra = 0; p_irdy = 100;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq("restart_req_seen", 32'(found), 32'd1);
        if (found) check_eq("restart_addr", imem_addr, RESET_PC);
        run(10);

        // Randomized traffic with occasional redirects and resets.
        for (int blk = 0; blk < 15; blk++) begin
            p_rdy   = $urandom_range(30, 100);
            p_irdy  = $urandom_range(20, 100);
            p_pcsrc = $urandom_range(0, 15);
            extra   = $urandom_range(0, 3);
            for (int i = 0; i < 200; i++) begin
                rst_drv = ($urandom_range(0, 149) != 0);
                step();
            end
        end
        rst_drv = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
